sprite_move_arbiter: RTL and testbench

Shares the sprite position engine's single 4-bit direction input between two requesters: the player buttons and an autopilot (demo) source. Generates the movement tick, cancels opposing directions, and runs a mode FSM that falls back to demo after an idle timeout. Sits between the button inputs/autopilot logic and the sprite position engine.

---
 rtl/sprite_ctrl_pkg.sv | 31 +++
 rtl/tick_gen.sv | 26 ++
 rtl/sprite_move_arbiter.sv | 95 +++++++++
 tb/tb_sprite_move_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sprite_ctrl_pkg.sv
// Shared types and helpers for the sprite movement arbiter: mode encoding,
// direction bit positions and the opposing-direction sanitizer.
package sprite_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_PLAYER = 2'b01,
    MODE_DEMO   = 2'b10
  } mode_e;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  // Opposing directions cancel pairwise; the other axis is left untouched.
  function automatic logic [3:0] sanitize(input logic [3:0] dir);
    logic [3:0] s;
    s = dir;
    if (dir[DIR_UP] && dir[DIR_DOWN]) begin
      s[DIR_UP]   = 1'b0;
      s[DIR_DOWN] = 1'b0;
    end
    if (dir[DIR_LEFT] && dir[DIR_RIGHT]) begin
      s[DIR_LEFT]  = 1'b0;
      s[DIR_RIGHT] = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: step_en is high for one cycle every TICK_PERIOD cycles,
// on the last count before the wrap.
module tick_gen #(
  parameter int TICK_PERIOD = 1048576
) (
  input  logic clock,
  input  logic reset,
  output logic step_en
);

  localparam int CW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    step_en = (cnt_q == LAST);
    cnt_d   = step_en ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sprite_move_arbiter.sv
// Arbitrates the sprite direction input between player buttons and an autopilot,
// with a tick-paced mode FSM that drops into demo after a button-idle timeout.
module sprite_move_arbiter
  import sprite_ctrl_pkg::*;
#(
  parameter int TICK_PERIOD = 1048576,
  parameter int IDLE_TICKS  = 600,
  parameter int DEMO_ENABLE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] btn_control,
  input  logic [3:0] auto_control,
  input  logic       auto_valid,
  output logic [3:0] control,
  output logic       tick,
  output logic [1:0] mode
);

  localparam int IW = $clog2(IDLE_TICKS + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TICKS);

  logic          step_en;
  logic [3:0]    btn_meta_q, btn_meta_d;
  logic [3:0]    btn_sync_q, btn_sync_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  mode_e         state_q, state_d;
  logic [3:0]    control_q, control_d;
  logic          tick_q, tick_d;
  logic [3:0]    btn_san;
  logic          pressed;
  logic          timed_out;

  tick_gen #(.TICK_PERIOD(TICK_PERIOD)) u_tick_gen (
    .clock  (clock),
    .reset  (reset),
    .step_en(step_en)
  );

  always_comb begin
    btn_meta_d = btn_control;
    btn_sync_d = btn_meta_q;
    btn_san    = sanitize(btn_sync_q);
    pressed    = (btn_san != 4'b0000);
    // Timeout looks at the count before this tick's update.
    timed_out  = (idle_cnt_q == IDLE_MAX) && auto_valid && (DEMO_ENABLE != 0);
    tick_d     = step_en;
    idle_cnt_d = idle_cnt_q;
    state_d    = state_q;
    control_d  = control_q;

    if (step_en) begin
      if (pressed)                 idle_cnt_d = '0;
      else if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + 1'b1;

      unique case (state_q)
        MODE_IDLE:   if (pressed) state_d = MODE_PLAYER;
                     else if (timed_out) state_d = MODE_DEMO;
        MODE_PLAYER: if (!pressed) state_d = MODE_IDLE;
        MODE_DEMO:   if (pressed) state_d = MODE_PLAYER;
                     else if (!auto_valid) state_d = MODE_IDLE;
        default:     state_d = MODE_IDLE;
      endcase

      unique case (state_d)
        MODE_PLAYER: control_d = btn_san;
        MODE_DEMO:   control_d = sanitize(auto_control);
        default:     control_d = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      idle_cnt_q <= '0;
      state_q    <= MODE_IDLE;
      control_q  <= '0;
      tick_q     <= 1'b0;
    end else begin
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      idle_cnt_q <= idle_cnt_d;
      state_q    <= state_d;
      control_q  <= control_d;
      tick_q     <= tick_d;
    end
  end

  assign control = control_q;
  assign tick    = tick_q;
  assign mode    = state_q;

endmodule

// File: tb/tb_sprite_move_arbiter.sv
// Directed test-plan walk followed by randomized traffic, all outputs checked
// every cycle against a behavioural model of the arbitration rules.
module tb_sprite_move_arbiter;

  localparam int TP = 4;
  localparam int IT = 3;
  localparam logic [1:0] M_IDLE = 2'b00, M_PLAYER = 2'b01, M_DEMO = 2'b10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn_control = 4'b0;
  logic [3:0] auto_control = 4'b0;
  logic       auto_valid = 1'b0;
  logic [3:0] control;
  logic       tick;
  logic [1:0] mode;

  int ncmp = 0;
  int nfail = 0;

  // model state
  int         m_cnt, m_idle;
  logic [1:0] m_mode;
  logic [3:0] m_s1, m_s2, m_ctl;
  logic       m_tk;

  sprite_move_arbiter #(.TICK_PERIOD(TP), .IDLE_TICKS(IT), .DEMO_ENABLE(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_control (btn_control),
    .auto_control(auto_control),
    .auto_valid  (auto_valid),
    .control     (control),
    .tick        (tick),
    .mode        (mode)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] ref_san(input logic [3:0] v);
    logic [1:0] ud, lr;
    ud = v[3:2];
    lr = v[1:0];
    if (ud == 2'b11) ud = 2'b00;
    if (lr == 2'b11) lr = 2'b00;
    return {ud, lr};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idle = 0; m_mode = M_IDLE;
    m_s1 = 4'b0; m_s2 = 4'b0; m_ctl = 4'b0; m_tk = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] b;
    logic       step, pressed;
    if (!reset) begin
      model_reset();
      return;
    end
    b       = ref_san(m_s2);
    pressed = (b != 4'b0);
    step    = (m_cnt == TP - 1);
    m_tk    = step;
    if (step) begin
      case (m_mode)
        M_IDLE:   if (pressed) m_mode = M_PLAYER;
                  else if (m_idle == IT && auto_valid) m_mode = M_DEMO;
        M_PLAYER: if (!pressed) m_mode = M_IDLE;
        default:  if (pressed) m_mode = M_PLAYER;
                  else if (!auto_valid) m_mode = M_IDLE;
      endcase
      m_idle = pressed ? 0 : ((m_idle + 1 > IT) ? IT : m_idle + 1);
      m_ctl  = (m_mode == M_PLAYER) ? b :
               (m_mode == M_DEMO)   ? ref_san(auto_control) : 4'b0;
    end
    m_s2  = m_s1;
    m_s1  = btn_control;
    m_cnt = (m_cnt + 1) % TP;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("control", control, m_ctl);
    chk("tick", {3'b0, tick}, {3'b0, m_tk});
    chk("mode", {2'b0, mode}, {2'b0, m_mode});
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_edge();
      #1;
      chk_model();
    end
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset(input int hold);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_control", control, 4'b0);
    chk("rst_tick", {3'b0, tick}, 4'b0);
    chk("rst_mode", {2'b0, mode}, 4'b0);
    cyc(hold);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    // reset held low for 5 cycles
    cyc(5);
    chk("reset_control", control, 4'b0);
    chk("reset_mode", {2'b0, mode}, 4'b0);
    reset = 1'b1;
    cyc(3);
    chk("first_tick_not_early", {3'b0, tick}, 4'b0);
    cyc(1);
    chk("first_tick", {3'b0, tick}, 4'b1);
    cyc(4);
    chk("second_tick", {3'b0, tick}, 4'b1);

    // player up, then release
    btn_control = 4'b1000;
    cyc(8);
    chk("player_mode", {2'b0, mode}, {2'b0, M_PLAYER});
    chk("player_ctl", control, 4'b1000);
    btn_control = 4'b0000;
    cyc(8);
    chk("release_mode", {2'b0, mode}, {2'b0, M_IDLE});
    chk("release_ctl", control, 4'b0000);

    // cancellation
    btn_control = 4'b1100;
    cyc(8);
    chk("cancel_mode", {2'b0, mode}, {2'b0, M_IDLE});
    chk("cancel_ctl", control, 4'b0000);
    btn_control = 4'b1110;
    cyc(8);
    chk("partial_cancel_mode", {2'b0, mode}, {2'b0, M_PLAYER});
    chk("partial_cancel_ctl", control, 4'b0010);

    // demo entry on the 4th tick after reset
    btn_control  = 4'b0000;
    auto_valid   = 1'b1;
    auto_control = 4'b0001;
    async_reset(2);
    cyc(15);
    chk("demo_not_yet", {2'b0, mode}, {2'b0, M_IDLE});
    cyc(1);
    chk("demo_mode", {2'b0, mode}, {2'b0, M_DEMO});
    chk("demo_ctl", control, 4'b0001);
    chk("demo_tick", {3'b0, tick}, 4'b1);

    // preemption, back to idle, demo re-entry
    btn_control = 4'b0100;
    cyc(8);
    chk("preempt_mode", {2'b0, mode}, {2'b0, M_PLAYER});
    chk("preempt_ctl", control, 4'b0100);
    btn_control = 4'b0000;
    cyc(8);
    chk("back_idle", {2'b0, mode}, {2'b0, M_IDLE});
    cyc(12);
    chk("demo_reentry", {2'b0, mode}, {2'b0, M_DEMO});

    // auto_valid drop and return
    auto_valid = 1'b0;
    cyc(4);
    chk("drop_mode", {2'b0, mode}, {2'b0, M_IDLE});
    chk("drop_ctl", control, 4'b0000);
    auto_valid = 1'b1;
    cyc(4);
    chk("raise_mode", {2'b0, mode}, {2'b0, M_DEMO});

    // reset mid-period in demo, tick spacing restarts
    cyc(2);
    async_reset(3);
    cyc(3);
    chk("restart_no_tick", {3'b0, tick}, 4'b0);
    cyc(1);
    chk("restart_tick", {3'b0, tick}, 4'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0)
        btn_control = ($urandom_range(1) == 0) ? 4'b0 : 4'($urandom_range(15));
      if ($urandom_range(19) == 0) auto_valid = ~auto_valid;
      if ($urandom_range(5) == 0) auto_control = 4'($urandom_range(15));
      if ($urandom_range(499) == 0) async_reset($urandom_range(1, 3));
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
